// File: rtl/cache_set_pkg.sv
// Shared types and constants for the 4-way cache set controller.
package cache_set_pkg;

    localparam int unsigned NUM_WAYS = 4;
    localparam int unsigned WAY_W    = 2;

    typedef enum logic [1:0] {
        IDLE,
        LOOKUP,
        REFILL,
        RESP
    } state_t;

    typedef logic [WAY_W-1:0] way_idx_t;

endpackage

// File: rtl/cache_tag_match_4.sv
// Combinational tag comparator for a 4-way set: reports the hit way and the
// lowest-numbered invalid way.
module cache_tag_match_4
    import cache_set_pkg::*;
#(
    parameter int unsigned TAG_W = 8
)
(
    input  logic [NUM_WAYS-1:0][TAG_W-1:0] tags,
    input  logic [NUM_WAYS-1:0]            valid,
    input  logic [TAG_W-1:0]               lookup_tag,
    output logic                           hit,
    output way_idx_t                       hit_way,
    output logic                           any_invalid,
    output way_idx_t                       first_invalid_way
);

    // Scan ways upward; the first invalid way found is kept, a tag can match at most once.
    always_comb begin
        hit               = 1'b0;
        hit_way           = '0;
        any_invalid       = 1'b0;
        first_invalid_way = '0;
        for (int unsigned i = 0; i < NUM_WAYS; i++) begin
            if (valid[i] && (tags[i] == lookup_tag)) begin
                hit     = 1'b1;
                hit_way = way_idx_t'(i);
            end
            if (!valid[i] && !any_invalid) begin
                any_invalid       = 1'b1;
                first_invalid_way = way_idx_t'(i);
            end
        end
    end

endmodule

// File: rtl/cache_set_ctrl_4_elmt.sv
// Tag-lookup and refill controller for one 4-way cache set, feeding the
// 4-element LRU tracker. Optional hit/miss counters are enabled by defining
// CACHE_SET_CTRL_STATS_EN.
module cache_set_ctrl_4_elmt
    import cache_set_pkg::*;
#(
    parameter int unsigned TAG_W = 8
)
(
    input  logic             clk,
    input  logic             rst,
    input  logic             req_v_i,
    input  logic [TAG_W-1:0] req_tag_i,
    output logic             req_ready_o,
    input  logic             flush_i,
    output logic             resp_v_o,
    output logic             resp_hit_o,
    output logic [1:0]       resp_way_o,
    output logic             refill_v_o,
    output logic [TAG_W-1:0] refill_tag_o,
    input  logic             refill_ack_i,
    input  logic [1:0]       lru_index_i,
    output logic             lru_access_o,
    output logic [1:0]       lru_way_o
`ifdef CACHE_SET_CTRL_STATS_EN
    ,
    output logic [15:0]      hit_cnt_o,
    output logic [15:0]      miss_cnt_o
`endif
);

    state_t                        state;
    logic [NUM_WAYS-1:0]           valid;
    logic [NUM_WAYS-1:0][TAG_W-1:0] tags;
    logic [TAG_W-1:0]              tag_q;
    way_idx_t                      way_q;
    logic                          hit_flag;

    logic                          m_hit;
    way_idx_t                      m_hit_way;
    logic                          m_any_invalid;
    way_idx_t                      m_first_invalid;

    cache_tag_match_4 #(.TAG_W(TAG_W)) u_match (
        .tags              (tags),
        .valid             (valid),
        .lookup_tag        (tag_q),
        .hit               (m_hit),
        .hit_way           (m_hit_way),
        .any_invalid       (m_any_invalid),
        .first_invalid_way (m_first_invalid)
    );

    // Ready is held low while reset is asserted so every output reads 0 in reset.
    assign req_ready_o = rst & (state == IDLE) & ~flush_i;

    // Controller FSM; response and tracker strobes are registered on leaving RESP.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= IDLE;
            valid        <= '0;
            tags         <= '0;
            tag_q        <= '0;
            way_q        <= '0;
            hit_flag     <= 1'b0;
            refill_v_o   <= 1'b0;
            refill_tag_o <= '0;
            resp_v_o     <= 1'b0;
            resp_hit_o   <= 1'b0;
            resp_way_o   <= '0;
            lru_access_o <= 1'b0;
            lru_way_o    <= '0;
        end else begin
            resp_v_o     <= 1'b0;
            resp_hit_o   <= 1'b0;
            resp_way_o   <= '0;
            lru_access_o <= 1'b0;
            lru_way_o    <= '0;
            case (state)
                IDLE: begin
                    if (flush_i) begin
                        valid <= '0;
                    end else if (req_v_i) begin
                        tag_q <= req_tag_i;
                        state <= LOOKUP;
                    end
                end
                LOOKUP: begin
                    if (m_hit) begin
                        way_q    <= m_hit_way;
                        hit_flag <= 1'b1;
                        state    <= RESP;
                    end else begin
                        way_q        <= m_any_invalid ? m_first_invalid : lru_index_i;
                        refill_v_o   <= 1'b1;
                        refill_tag_o <= tag_q;
                        state        <= REFILL;
                    end
                end
                REFILL: begin
                    if (refill_ack_i) begin
                        tags[way_q]  <= tag_q;
                        valid[way_q] <= 1'b1;
                        hit_flag     <= 1'b0;
                        refill_v_o   <= 1'b0;
                        refill_tag_o <= '0;
                        state        <= RESP;
                    end
                end
                RESP: begin
                    resp_v_o     <= 1'b1;
                    resp_hit_o   <= hit_flag;
                    resp_way_o   <= way_q;
                    lru_access_o <= 1'b1;
                    lru_way_o    <= way_q;
                    state        <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef CACHE_SET_CTRL_STATS_EN
    // Saturating hit/miss counters, cleared by a flush honoured in IDLE.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hit_cnt_o  <= '0;
            miss_cnt_o <= '0;
        end else if ((state == IDLE) && flush_i) begin
            hit_cnt_o  <= '0;
            miss_cnt_o <= '0;
        end else if (state == RESP) begin
            if (hit_flag) begin
                if (hit_cnt_o != '1) hit_cnt_o <= hit_cnt_o + 16'd1;
            end else begin
                if (miss_cnt_o != '1) miss_cnt_o <= miss_cnt_o + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_cache_set_ctrl_4_elmt.sv
// Self-checking bench for cache_set_ctrl_4_elmt. Counter checks are active
// when CACHE_SET_CTRL_STATS_EN is defined.
module tb_cache_set_ctrl_4_elmt;

    logic       clk = 1'b0;
    logic       rst;
    logic       req_v_i = 1'b0;
    logic [7:0] req_tag_i = '0;
    logic       req_ready_o;
    logic       flush_i = 1'b0;
    logic       resp_v_o;
    logic       resp_hit_o;
    logic [1:0] resp_way_o;
    logic       refill_v_o;
    logic [7:0] refill_tag_o;
    logic       refill_ack_i = 1'b0;
    logic [1:0] lru_index_i = '0;
    logic       lru_access_o;
    logic [1:0] lru_way_o;
`ifdef CACHE_SET_CTRL_STATS_EN
    logic [15:0] hit_cnt_o;
    logic [15:0] miss_cnt_o;
`endif

    cache_set_ctrl_4_elmt #(.TAG_W(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_v_i      (req_v_i),
        .req_tag_i    (req_tag_i),
        .req_ready_o  (req_ready_o),
        .flush_i      (flush_i),
        .resp_v_o     (resp_v_o),
        .resp_hit_o   (resp_hit_o),
        .resp_way_o   (resp_way_o),
        .refill_v_o   (refill_v_o),
        .refill_tag_o (refill_tag_o),
        .refill_ack_i (refill_ack_i),
        .lru_index_i  (lru_index_i),
        .lru_access_o (lru_access_o),
        .lru_way_o    (lru_way_o)
`ifdef CACHE_SET_CTRL_STATS_EN
        ,
        .hit_cnt_o    (hit_cnt_o),
        .miss_cnt_o   (miss_cnt_o)
`endif
    );

    always #5 clk = ~clk;

    int unsigned n_pass  = 0;
    int unsigned n_total = 0;

    // Expected output values for the current cycle.
    logic       e_ready = 1'b0;
    logic       e_resp_v = 1'b0;
    logic       e_resp_hit = 1'b0;
    logic [1:0] e_resp_way = '0;
    logic       e_refill_v = 1'b0;
    logic [7:0] e_refill_tag = '0;
    logic       e_lru_acc = 1'b0;
    logic [1:0] e_lru_way = '0;

    // Behavioural model of the set contents and statistics.
    bit         m_valid [4];
    logic [7:0] m_tag   [4];
    int unsigned m_hits   = 0;
    int unsigned m_misses = 0;

    // Response captured from the DUT for literal checks.
    bit         got_seen;
    logic       got_hit;
    logic [1:0] got_way;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Every cycle: all outputs against the model's expectations.
    always @(negedge clk) begin
        chk("req_ready", req_ready_o, e_ready);
        chk("resp_v", resp_v_o, e_resp_v);
        chk("refill_v", refill_v_o, e_refill_v);
        chk("lru_access", lru_access_o, e_lru_acc);
        if (e_resp_v) begin
            chk("resp_hit", resp_hit_o, e_resp_hit);
            chk("resp_way", resp_way_o, e_resp_way);
        end
        if (e_lru_acc) chk("lru_way", lru_way_o, e_lru_way);
        if (e_refill_v) chk("refill_tag", refill_tag_o, e_refill_tag);
`ifdef CACHE_SET_CTRL_STATS_EN
        chk("hit_cnt", hit_cnt_o, m_hits);
        chk("miss_cnt", miss_cnt_o, m_misses);
`endif
        if (resp_v_o) begin
            got_seen = 1'b1;
            got_hit  = resp_hit_o;
            got_way  = resp_way_o;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_clear();
        for (int i = 0; i < 4; i++) begin
            m_valid[i] = 1'b0;
            m_tag[i]   = '0;
        end
    endtask

    // One full request; entered and left one step after a rising edge with the DUT idle.
    task automatic do_req(input logic [7:0] tag, input int unsigned ack_dly, input logic [1:0] lru,
                          output bit hit, output logic [1:0] way);
        got_seen    = 1'b0;
        req_v_i     = 1'b1;
        req_tag_i   = tag;
        lru_index_i = lru;
        tick();
        req_v_i = 1'b0;
        e_ready = 1'b0;
        hit = 1'b0;
        way = '0;
        for (int i = 0; i < 4; i++)
            if (m_valid[i] && m_tag[i] == tag) begin
                hit = 1'b1;
                way = 2'(i);
            end
        if (!hit) begin
            bit found = 1'b0;
            for (int i = 0; i < 4; i++)
                if (!m_valid[i] && !found) begin
                    found = 1'b1;
                    way   = 2'(i);
                end
            if (!found) way = lru;
        end
        tick();
        if (!hit) begin
            e_refill_v   = 1'b1;
            e_refill_tag = tag;
            for (int unsigned d = 0; d < ack_dly; d++) tick();
            refill_ack_i = 1'b1;
            tick();
            refill_ack_i = 1'b0;
            e_refill_v   = 1'b0;
            m_valid[way] = 1'b1;
            m_tag[way]   = tag;
        end
        tick();
        e_resp_v   = 1'b1;
        e_resp_hit = hit;
        e_resp_way = way;
        e_lru_acc  = 1'b1;
        e_lru_way  = way;
        e_ready    = 1'b1;
        if (hit) begin
            if (m_hits < 16'hFFFF) m_hits++;
        end else begin
            if (m_misses < 16'hFFFF) m_misses++;
        end
        tick();
        e_resp_v  = 1'b0;
        e_lru_acc = 1'b0;
    endtask

    // Request with literal expectations on both the model and the DUT response.
    task automatic req_expect(input string name, input logic [7:0] tag, input int unsigned ack_dly,
                              input logic [1:0] lru, input bit exp_hit, input logic [1:0] exp_way);
        bit         h;
        logic [1:0] w;
        do_req(tag, ack_dly, lru, h, w);
        chk({name, "_model_hit"}, h, exp_hit);
        chk({name, "_model_way"}, w, exp_way);
        chk({name, "_seen"}, got_seen, 1'b1);
        chk({name, "_dut_hit"}, got_hit, exp_hit);
        chk({name, "_dut_way"}, got_way, exp_way);
    endtask

    task automatic do_flush();
        flush_i   = 1'b1;
        req_v_i   = 1'b1;
        req_tag_i = 8'hAA;
        e_ready   = 1'b0;
        tick();
        flush_i  = 1'b0;
        req_v_i  = 1'b0;
        e_ready  = 1'b1;
        model_clear();
        m_hits   = 0;
        m_misses = 0;
        tick();
    endtask

    initial begin
        bit         h;
        logic [1:0] w;
        model_clear();
        rst = 1'b1;
        #1 rst = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset_ready", req_ready_o, 1'b0);
        @(posedge clk);
        #1 rst = 1'b1;
        e_ready = 1'b1;
        #1 chk("reset_release_ready", req_ready_o, 1'b1);
        tick();

        // Cold misses fill ways 0..3 in order.
        req_expect("cold10", 8'h10, 2, 2'd3, 1'b0, 2'd0);
        req_expect("cold20", 8'h20, 2, 2'd3, 1'b0, 2'd1);
        req_expect("cold30", 8'h30, 2, 2'd3, 1'b0, 2'd2);
        req_expect("cold40", 8'h40, 2, 2'd3, 1'b0, 2'd3);
        req_expect("hit20",  8'h20, 2, 2'd0, 1'b1, 2'd1);
`ifdef CACHE_SET_CTRL_STATS_EN
        chk("stats_miss4", miss_cnt_o, 16'd4);
        chk("stats_hit1", hit_cnt_o, 16'd1);
`endif

        // Full set: victim follows the tracker.
        req_expect("lru55",  8'h55, 1, 2'd2, 1'b0, 2'd2);
        req_expect("lru30",  8'h30, 0, 2'd0, 1'b0, 2'd0);
        req_expect("hit55",  8'h55, 0, 2'd1, 1'b1, 2'd2);

        // Flush with a simultaneous request: request ignored, set emptied.
        do_flush();
`ifdef CACHE_SET_CTRL_STATS_EN
        chk("stats_flush_miss", miss_cnt_o, 16'd0);
        chk("stats_flush_hit", hit_cnt_o, 16'd0);
`endif
        req_expect("flush10", 8'h10, 1, 2'd3, 1'b0, 2'd0);

        // Long refill stall, then reset in the middle of it.
        req_v_i     = 1'b1;
        req_tag_i   = 8'h77;
        lru_index_i = 2'd1;
        tick();
        req_v_i = 1'b0;
        e_ready = 1'b0;
        tick();
        e_refill_v   = 1'b1;
        e_refill_tag = 8'h77;
        repeat (20) tick();
        #2 rst = 1'b0;
        e_refill_v = 1'b0;
        #1;
        chk("midrst_refill_v", refill_v_o, 1'b0);
        chk("midrst_resp_v", resp_v_o, 1'b0);
        chk("midrst_ready", req_ready_o, 1'b0);
        chk("midrst_lru_acc", lru_access_o, 1'b0);
        chk("midrst_refill_tag", refill_tag_o, 8'h00);
        model_clear();
        m_hits   = 0;
        m_misses = 0;
        repeat (3) tick();
        rst     = 1'b1;
        e_ready = 1'b1;
        #1 chk("postrst_ready", req_ready_o, 1'b1);
        tick();
        req_expect("postrst10", 8'h10, 0, 2'd3, 1'b0, 2'd0);
        req_expect("postrst20", 8'h20, 0, 2'd3, 1'b0, 2'd1);

        // Randomized traffic against the model.
        for (int n = 0; n < 80; n++) begin
            if ($urandom_range(0, 9) == 0) do_flush();
            do_req(8'($urandom_range(0, 6) * 16 + 5), $urandom_range(0, 4),
                   2'($urandom_range(0, 3)), h, w);
            repeat ($urandom_range(0, 2)) tick();
        end

        repeat (2) tick();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
